ed25519_verify_ctrl: RTL
========================

ED25519_VERIFY_CTRL -- requirements
Module: ed25519_verify_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 65535, max cycles waited for any engine done.
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 sync active-high reset.
REQ-003 SHALL have: start in 1 request pulse; pub_key in 256 A; sig_r in 256 R; sig_s in 256 S; msg in 256 message bytes; msg_len in 7 message byte count.
REQ-004 SHALL have: busy out 1; done out 1 one-cycle completion pulse; valid out 1 signature accepted; err out 2 result code.
REQ-005 SHALL have hash-engine port: hash_start out 1; hash_din out 768; hash_len out 8 bytes; hash_done in 1; hash_dout in 512 digest.
REQ-006 SHALL have point-engine port: pt_start out 1; pt_op out 2; pt_point out 256; pt_scalar_s out 256; pt_scalar_h out 512; pt_done in 1; pt_fail in 1; pt_result in 256 encoded point.
REQ-007 All 256-bit values SHALL be RFC 8032 byte strings, byte 0 at [7:0]; scalars read as little-endian integers.
REQ-008 Reset SHALL be synchronous, active-high, on rst, single clock clk.

Function
REQ-009 States SHALL be IDLE, CHECK, DECOMP, HASH, MUL, FINISH.
REQ-010 In IDLE, start=1 SHALL latch all inputs and enter CHECK next cycle (cycle T+1); start outside IDLE SHALL be ignored.
REQ-011 busy SHALL be 1 in every state except IDLE.
REQ-012 CHECK (one cycle) SHALL reject if msg_len>32 or S >= L, L = 0x1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed; reject -> FINISH, err=01.
REQ-013 On CHECK pass, SHALL pulse pt_start one cycle with pt_op=00 (decompress), pt_point=A, entering DECOMP.
REQ-014 DECOMP: pt_done with pt_fail=1 -> FINISH err=10; pt_done with pt_fail=0 -> pulse hash_start, enter HASH.
REQ-015 hash_din SHALL be R at [255:0], A at [511:256], msg at [767:512]; hash_len = 64 + msg_len; bytes beyond msg_len SHALL be zero.
REQ-016 HASH: on hash_done, SHALL pulse pt_start with pt_op=01 (compute encode([S]B - [h]A)), pt_scalar_s=S, pt_scalar_h=hash_dout, pt_point=A, enter MUL.
REQ-017 MUL: on pt_done, SHALL set valid = (pt_result == R) and err=00 (pt_fail=1 here SHALL give valid=0, err=10), enter FINISH.
REQ-018 FINISH SHALL pulse done for exactly one cycle, then return to IDLE.
REQ-019 Rejection path latency: start at T -> done=1 at T+2.
REQ-020 Engine start outputs SHALL be single-cycle pulses; pt_op, pt_point, pt_scalar_*, hash_din, hash_len SHALL hold stable from start pulse until the matching done.
REQ-021 hash_done/pt_done arriving in a state not waiting for them SHALL be ignored.
REQ-022 Wait counter SHALL clear on each engine start pulse and increment each waiting cycle; reaching TIMEOUT_CYC without done -> FINISH, err=11, valid=0.
REQ-023 done input in same cycle counter reaches TIMEOUT_CYC SHALL take precedence over timeout.
REQ-024 valid and err SHALL hold from done until the next accepted start, then clear to 0.
REQ-025 valid SHALL only be 1 when err=00.

Reset
REQ-026 rst=1 SHALL force IDLE, busy=0, done=0, valid=0, err=00, hash_start=0, pt_start=0, wait counter=0, in any state including mid-operation.
REQ-027 Engine done inputs arriving after reset release from an aborted run SHALL be ignored (IDLE).

Verification
REQ-028 RFC 8032 TEST 1 (A=d75a98..511a, R=e55643..490155, S=5fb882..7a100b, msg_len=0), model engines return pt_result=R -> hash_len=64, done once, valid=1, err=00.
REQ-029 Same inputs, S = L exactly -> done at T+2, no pt_start/hash_start ever, valid=0, err=01; msg_len=33 -> identical response.
REQ-030 Model pt_fail=1 on decompress -> no hash_start, done next cycle after pt_done, err=10, valid=0.
REQ-031 TIMEOUT_CYC=16, hash engine never responds -> done exactly 16 waiting cycles after hash_start, err=11; hash_done at cycle 16 instead -> proceeds to MUL.
REQ-032 Model returns pt_result = R with bit 0 flipped -> valid=0, err=00; second start during busy ignored (one done only).
REQ-033 rst asserted in MUL, then late pt_done -> outputs at reset values, no done pulse, next start runs normally.

Source files
------------

// File: rtl/ed25519_verify_ctrl.sv
// Ed25519 verification sequencer: range-checks S, has A decompressed, hashes
// R || A || M, asks the point engine for encode([S]B - [h]A), and compares the
// result to R. Each engine wait is bounded by TIMEOUT_CYC cycles.
module ed25519_verify_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] pub_key,
  input  logic [255:0] sig_r,
  input  logic [255:0] sig_s,
  input  logic [255:0] msg,
  input  logic [6:0]   msg_len,
  output logic         busy,
  output logic         done,
  output logic         valid,
  output logic [1:0]   err,
  output logic         hash_start,
  output logic [767:0] hash_din,
  output logic [7:0]   hash_len,
  input  logic         hash_done,
  input  logic [511:0] hash_dout,
  output logic         pt_start,
  output logic [1:0]   pt_op,
  output logic [255:0] pt_point,
  output logic [255:0] pt_scalar_s,
  output logic [511:0] pt_scalar_h,
  input  logic         pt_done,
  input  logic         pt_fail,
  input  logic [255:0] pt_result
);

  // Group order of the Ed25519 base point; canonical S must be below it.
  localparam logic [255:0] ORDER_L =
    256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_RANGE   = 2'b01;
  localparam logic [1:0] ERR_ENGINE  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [1:0] OP_DECOMP = 2'b00;
  localparam logic [1:0] OP_VERIFY = 2'b01;

  typedef enum logic [2:0] {IDLE, CHECK, DECOMP, HASH, MUL, FINISH} state_t;

  state_t         state, state_nxt;
  logic [255:0]   a_q, r_q, s_q, msg_q;
  logic [6:0]     len_q;
  logic [511:0]   h_q;
  logic [31:0]    wait_cnt;
  logic           pt_start_q, hash_start_q;
  logic           valid_q;
  logic [1:0]     err_q;
  logic           timeout;
  logic           latch_en, fin_set, fin_valid, pt_go, hash_go, h_load;
  logic [1:0]     fin_err;

  // Zero every message byte at or beyond the byte count so the hash input
  // never carries stale bytes.
  function automatic logic [255:0] mask_msg(input logic [255:0] m, input logic [6:0] n);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (7'(i) < n) r[i*8 +: 8] = m[i*8 +: 8];
    end
    return r;
  endfunction

  assign timeout = (wait_cnt == TIMEOUT_CYC);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-cycle control decisions; engine done wins over timeout.
  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    fin_set   = 1'b0;
    fin_valid = 1'b0;
    fin_err   = ERR_OK;
    pt_go     = 1'b0;
    hash_go   = 1'b0;
    h_load    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          latch_en  = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (len_q > 7'd32 || s_q >= ORDER_L) begin
          fin_set   = 1'b1;
          fin_err   = ERR_RANGE;
          state_nxt = FINISH;
        end else begin
          pt_go     = 1'b1;
          state_nxt = DECOMP;
        end
      end
      DECOMP: begin
        if (pt_done) begin
          if (pt_fail) begin
            fin_set   = 1'b1;
            fin_err   = ERR_ENGINE;
            state_nxt = FINISH;
          end else begin
            hash_go   = 1'b1;
            state_nxt = HASH;
          end
        end else if (timeout) begin
          fin_set   = 1'b1;
          fin_err   = ERR_TIMEOUT;
          state_nxt = FINISH;
        end
      end
      HASH: begin
        if (hash_done) begin
          h_load    = 1'b1;
          pt_go     = 1'b1;
          state_nxt = MUL;
        end else if (timeout) begin
          fin_set   = 1'b1;
          fin_err   = ERR_TIMEOUT;
          state_nxt = FINISH;
        end
      end
      MUL: begin
        if (pt_done) begin
          fin_set   = 1'b1;
          fin_valid = !pt_fail && (pt_result == r_q);
          fin_err   = pt_fail ? ERR_ENGINE : ERR_OK;
          state_nxt = FINISH;
        end else if (timeout) begin
          fin_set   = 1'b1;
          fin_err   = ERR_TIMEOUT;
          state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: engine start pulses, wait counter, held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      pt_start_q   <= 1'b0;
      hash_start_q <= 1'b0;
      wait_cnt     <= '0;
      valid_q      <= 1'b0;
      err_q        <= ERR_OK;
    end else begin
      pt_start_q   <= pt_go;
      hash_start_q <= hash_go;
      if (pt_go || hash_go)
        wait_cnt <= '0;
      else if (state == DECOMP || state == HASH || state == MUL)
        wait_cnt <= wait_cnt + 32'd1;
      if (latch_en) begin
        valid_q <= 1'b0;
        err_q   <= ERR_OK;
      end else if (fin_set) begin
        valid_q <= fin_valid;
        err_q   <= fin_err;
      end
    end
  end

  // Request operands and digest; held untouched for the whole run.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      a_q   <= pub_key;
      r_q   <= sig_r;
      s_q   <= sig_s;
      msg_q <= mask_msg(msg, msg_len);
      len_q <= msg_len;
    end
    if (h_load) h_q <= hash_dout;
  end

  assign busy        = (state != IDLE);
  assign done        = (state == FINISH);
  assign valid       = valid_q;
  assign err         = err_q;
  assign hash_start  = hash_start_q;
  assign hash_din    = {msg_q, a_q, r_q};
  assign hash_len    = 8'd64 + {1'b0, len_q};
  assign pt_start    = pt_start_q;
  assign pt_op       = (state == MUL) ? OP_VERIFY : OP_DECOMP;
  assign pt_point    = a_q;
  assign pt_scalar_s = s_q;
  assign pt_scalar_h = h_q;

endmodule
